// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage RV32I pipeline.
// Optional HAZARD_CNT_EN adds saturating load-use / memory-wait counters.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_bubble,
    output logic              ifid_flush,
`ifdef HAZARD_CNT_EN
    output logic [15:0]       lu_stall_cnt,
    output logic [15:0]       mem_wait_cnt,
`endif
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    state_t state;

    // Shadow copies of the destination info for the EX and MEM stages.
    // A WB-stage producer is served by the register file write-through,
    // so nothing past MEM is needed for select generation.
    logic [REG_AW-1:0] ex_rd;
    logic              ex_rw;
    logic              ex_mr;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_rw;
    logic              mem_ld;

    logic              frozen;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              lu_hit;
    logic              flush_go;
    logic              stall_go;
    logic [1:0]        fwd_a_nx;
    logic [1:0]        fwd_b_nx;

    // Newest producer wins: EX result beats MEM result; x0 never forwards.
    function automatic logic [1:0] fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic              use_rs,
        input logic [REG_AW-1:0] e_rd,
        input logic              e_rw,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_rw
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_rs && rs != '0) begin
            if (e_rw && e_rd == rs) begin
                sel = 2'b10;
            end else if (m_rw && m_rd == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // A load stuck in MEM holds the whole pipe until memory answers.
    assign frozen   = mem_ld & ~dmem_ready;
    assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign lu_hit   = ex_mr & (ex_rd != '0) & id_valid & (rs1_hit | rs2_hit);
    assign flush_go = ex_flush & ~frozen;
    assign stall_go = lu_hit & ~flush_go & ~frozen;

    assign pc_we       = ~frozen & ~stall_go;
    assign ifid_we     = ~frozen & ~stall_go;
    assign idex_bubble = ~frozen & (flush_go | lu_hit);
    assign ifid_flush  = flush_go;
    assign state_o     = state;

    assign fwd_a_nx = fwd_pick(id_rs1, id_use_rs1, ex_rd, ex_rw, mem_rd, mem_rw);
    assign fwd_b_nx = fwd_pick(id_rs2, id_use_rs2, ex_rd, ex_rw, mem_rd, mem_rw);

    // FSM, shadow pipe advance and registered forwarding selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ex_rd     <= '0;
            ex_rw     <= 1'b0;
            ex_mr     <= 1'b0;
            mem_rd    <= '0;
            mem_rw    <= 1'b0;
            mem_ld    <= 1'b0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            unique case (state)
                RUN, LU_STALL: begin
                    if (frozen)        state <= MEM_WAIT;
                    else if (stall_go) state <= LU_STALL;
                    else               state <= RUN;
                end
                MEM_WAIT: begin
                    if (frozen)        state <= MEM_WAIT;
                    else if (stall_go) state <= LU_STALL;
                    else               state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (!frozen) begin
                if (id_valid && !idex_bubble) begin
                    ex_rd <= id_rd;
                    ex_rw <= id_reg_write & (id_rd != '0);
                    ex_mr <= id_mem_read;
                end else begin
                    ex_rd <= '0;
                    ex_rw <= 1'b0;
                    ex_mr <= 1'b0;
                end
                mem_rd    <= ex_rd;
                mem_rw    <= ex_rw;
                mem_ld    <= ex_mr;
                fwd_a_sel <= idex_bubble ? 2'b00 : fwd_a_nx;
                fwd_b_sel <= idex_bubble ? 2'b00 : fwd_b_nx;
            end
        end
    end

`ifdef HAZARD_CNT_EN
    // Saturating event counters: stall entries and memory-wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt <= 16'h0000;
            mem_wait_cnt <= 16'h0000;
        end else begin
            if (stall_go && lu_stall_cnt != 16'hFFFF) begin
                lu_stall_cnt <= lu_stall_cnt + 16'h0001;
            end
            if (state == MEM_WAIT && mem_wait_cnt != 16'hFFFF) begin
                mem_wait_cnt <= mem_wait_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed plan plus random traffic.
// Expected values come from an in-flight instruction list model.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_reg_write, id_mem_read;
    logic          ex_flush, dmem_ready;
    logic [1:0]    fwd_a_sel, fwd_b_sel, state_o;
    logic          pc_we, ifid_we, idex_bubble, ifid_flush;
`ifdef HAZARD_CNT_EN
    logic [15:0]   lu_stall_cnt, mem_wait_cnt;
`endif

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .dmem_ready   (dmem_ready),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
`ifdef HAZARD_CNT_EN
        .lu_stall_cnt (lu_stall_cnt),
        .mem_wait_cnt (mem_wait_cnt),
`endif
        .state_o      (state_o)
    );

    // In-flight list, newest first: [0] is in EX, [1] is in MEM.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
    } rec_t;

    typedef enum int {EV_NORMAL, EV_STALL, EV_FLUSH, EV_FREEZE} ev_t;

    rec_t       q[$];
    int         m_st;
    logic [1:0] m_a, m_b;
    int         m_lu, m_mw;
    int         vectors = 0;
    int         miscompares = 0;
    logic       o_pc, o_ifid, o_bub, o_fl;
    logic [1:0] o_st;
    int         mw_seen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        m_st = 0;
        m_a  = 2'b00;
        m_b  = 2'b00;
        m_lu = 0;
        m_mw = 0;
    endtask

    // Distance to the newest in-flight writer of rs picks the source.
    function automatic logic [1:0] model_sel(input logic [AW-1:0] rs,
                                             input logic u);
        if (!u || rs == 0) return 2'b00;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].wr && q[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic step(input logic v, input int rs1, input logic u1,
                        input int rs2, input logic u2, input int rd,
                        input logic rw, input logic mr, input logic fl,
                        input logic rdy);
        ev_t  ev;
        logic lu;
        logic e_pc, e_bub, e_fl;
        rec_t nr;
        logic [1:0] na, nb;
        id_valid     = v;
        id_rs1       = AW'(rs1);
        id_use_rs1   = u1;
        id_rs2       = AW'(rs2);
        id_use_rs2   = u2;
        id_rd        = AW'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        ex_flush     = fl;
        dmem_ready   = rdy;
        lu = q[0].ld && q[0].rd != 0 && v &&
             ((u1 && AW'(rs1) == q[0].rd) || (u2 && AW'(rs2) == q[0].rd));
        if (q[1].ld && !rdy) ev = EV_FREEZE;
        else if (fl)         ev = EV_FLUSH;
        else if (lu)         ev = EV_STALL;
        else                 ev = EV_NORMAL;
        case (ev)
            EV_FREEZE: begin e_pc = 0; e_bub = 0; e_fl = 0; end
            EV_FLUSH:  begin e_pc = 1; e_bub = 1; e_fl = 1; end
            EV_STALL:  begin e_pc = 0; e_bub = 1; e_fl = 0; end
            default:   begin e_pc = 1; e_bub = 0; e_fl = 0; end
        endcase
        @(negedge clk);
        o_pc = pc_we; o_ifid = ifid_we; o_bub = idex_bubble;
        o_fl = ifid_flush; o_st = state_o;
        chk("pc_we", pc_we, e_pc);
        chk("ifid_we", ifid_we, e_pc);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("ifid_flush", ifid_flush, e_fl);
        chk("state", state_o, m_st);
        chk("fwd_a", fwd_a_sel, m_a);
        chk("fwd_b", fwd_b_sel, m_b);
`ifdef HAZARD_CNT_EN
        chk("lu_cnt", lu_stall_cnt, m_lu);
        chk("mw_cnt", mem_wait_cnt, m_mw);
`endif
        @(posedge clk);
        if (m_st == 2 && m_mw < 65535) m_mw++;
        if (ev == EV_STALL && m_lu < 65535) m_lu++;
        if (ev != EV_FREEZE) begin
            nr = '0;
            na = 2'b00;
            nb = 2'b00;
            if (ev == EV_NORMAL) begin
                na = model_sel(AW'(rs1), u1);
                nb = model_sel(AW'(rs2), u2);
                if (v) begin
                    nr.rd = AW'(rd);
                    nr.wr = rw && rd != 0;
                    nr.ld = mr;
                end
            end
            q.push_front(nr);
            void'(q.pop_back());
            m_a = na;
            m_b = nb;
        end
        m_st = (ev == EV_FREEZE) ? 2 : (ev == EV_STALL) ? 1 : 0;
        #1;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 0;
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
        id_mem_read = 0; ex_flush = 0; dmem_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, 2'b00);
        chk("rst_fwd_a", fwd_a_sel, 2'b00);
        chk("rst_fwd_b", fwd_b_sel, 2'b00);
        chk("rst_pc_we", pc_we, 1'b1);
        chk("rst_ifid_we", ifid_we, 1'b1);
        chk("rst_bubble", idex_bubble, 1'b0);
        chk("rst_flush", ifid_flush, 1'b0);
        rst_n = 1;

        // add x5 ; add x6,x5,x1 at distance 1, 2, 3
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        chk("dist1_a", fwd_a_sel, 2'b10);
        chk("dist1_b", fwd_b_sel, 2'b00);
        nop(); nop();
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
        nop();
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        chk("dist2_a", fwd_a_sel, 2'b01);
        nop(); nop();
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
        nop(); nop();
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
        chk("dist3_a", fwd_a_sel, 2'b00);
        nop(); nop();

        // lw x7 ; add x8,x7,x7
        step(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1);
        chk("lu_pc_we", o_pc, 1'b0);
        chk("lu_ifid_we", o_ifid, 1'b0);
        chk("lu_bubble", o_bub, 1'b1);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1);
        chk("lu_state", o_st, 2'b01);
        chk("lu_pc_resume", o_pc, 1'b1);
        chk("lu_fwd_a", fwd_a_sel, 2'b01);
        chk("lu_fwd_b", fwd_b_sel, 2'b01);
        nop(); nop();

        // x0 never forwards or stalls
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0, 1);
        chk("x0_fwd_a", fwd_a_sel, 2'b00);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0, 1);
        chk("x0_no_stall", o_pc, 1'b1);
        nop(); nop();

        // add x3 ; lw x9 ; add x10,x3 with dmem_ready low 3 cycles
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
        step(1, 3, 1, 0, 0, 10, 1, 0, 0, 1);
        mw_seen = 0;
        step(1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
        chk("mw_freeze_pc", o_pc, 1'b0);
        if (o_st == 2'b10) mw_seen++;
        step(1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
        if (o_st == 2'b10) mw_seen++;
        step(1, 1, 1, 2, 1, 11, 1, 0, 0, 0);
        if (o_st == 2'b10) mw_seen++;
        chk("mw_fwd_held", fwd_a_sel, 2'b01);
        step(1, 1, 1, 2, 1, 11, 1, 0, 0, 1);
        if (o_st == 2'b10) mw_seen++;
        chk("mw_release_pc", o_pc, 1'b1);
`ifdef HAZARD_CNT_EN
        chk("mw_cnt3", mem_wait_cnt, 16'd3);
`endif
        nop();
        if (o_st == 2'b10) mw_seen++;
        chk("mw_cycles", mw_seen, 3);
        nop();

        // load-use hazard coinciding with a flush
        step(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
        step(1, 7, 1, 0, 0, 8, 1, 0, 1, 1);
        chk("fl_ifid_flush", o_fl, 1'b1);
        chk("fl_bubble", o_bub, 1'b1);
        chk("fl_pc_we", o_pc, 1'b1);
        chk("fl_state", state_o, 2'b00);
        nop(); nop();

        // reset pulsed during LU_STALL
        step(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
        step(1, 7, 1, 7, 1, 8, 1, 0, 0, 1);
        chk("pre_rst_state", state_o, 2'b01);
        #2 rst_n = 0;
        #1;
        chk("mrst_state", state_o, 2'b00);
        chk("mrst_pc_we", pc_we, 1'b1);
        chk("mrst_ifid_we", ifid_we, 1'b1);
        chk("mrst_bubble", idex_bubble, 1'b0);
        chk("mrst_flush", ifid_flush, 1'b0);
        chk("mrst_fwd_a", fwd_a_sel, 2'b00);
        chk("mrst_fwd_b", fwd_b_sel, 2'b00);
        model_reset();
        rst_n = 1;

        // random traffic over a small register set
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
